// File: rtl/climate_ctrl_pkg.sv
// Shared types and helpers for the climate actuator controller.
//   act_state_t : per-channel actuator FSM state
//   sat_add     : unsigned add clamped to 2^w-1
//   sat_sub     : unsigned subtract clamped to 0
package climate_ctrl_pkg;

  // Widest operand the saturating helpers support; callers zero-extend into it.
  localparam int unsigned SAT_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    LOWER = 2'd2,
    DEAD  = 2'd3
  } act_state_t;

  // a + b, clamped to the largest value representable in w bits (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    if (sum > lim) begin
      return lim[SAT_W-1:0];
    end
    return sum[SAT_W-1:0];
  endfunction

  // a - b, clamped at zero.
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    if (a >= b) begin
      return a - b;
    end
    return '0;
  endfunction

endpackage

// File: rtl/climate_actuator_ctrl_fsm.sv
// One hysteresis channel: latches samples, drives a raise/lower actuator pair with
// minimum-on time and a post-turn-off dead time during which both stay off.
// Ports:
//   pclk, presetn             clock, async active-low reset
//   ctrl_en                   0 forces the channel off (via DEAD)
//   sample_valid/sample_data  1-cycle sample strobe and data
//   lo_th, hi_th, hyst        thresholds and hysteresis band
//   raise_en, lower_en        actuator enables (decoded from registered state)
//   cfg_err                   lo_th >= hi_th (combinational)
module actuator_hyst_fsm
  import climate_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MIN_ON_CYC   = 1000,
  parameter int unsigned DEADTIME_CYC = 100
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              ctrl_en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] lo_th,
  input  logic [DATA_W-1:0] hi_th,
  input  logic [DATA_W-1:0] hyst,
  output logic              raise_en,
  output logic              lower_en,
  output logic              cfg_err
);

  localparam int unsigned CntMax = (MIN_ON_CYC > DEADTIME_CYC) ? MIN_ON_CYC : DEADTIME_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MinLast  = CntW'(MIN_ON_CYC - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEADTIME_CYC - 1);

  act_state_t        state_q, state_d;
  logic [DATA_W-1:0] sample_q;
  logic              sample_seen_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] raise_exit_th;
  logic [DATA_W-1:0] lower_exit_th;
  logic              min_done;
  logic              run_ok;

  assign cfg_err       = (lo_th >= hi_th);
  assign run_ok        = ctrl_en & ~cfg_err;
  assign min_done      = (cnt_q == MinLast);
  assign raise_exit_th = DATA_W'(sat_add(SAT_W'(lo_th), SAT_W'(hyst), DATA_W));
  assign lower_exit_th = DATA_W'(sat_sub(SAT_W'(hi_th), SAT_W'(hyst)));

  // The FSM always looks at the held sample; a strobe in the same cycle only
  // takes effect from the next cycle on.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sample_seen_q && run_ok) begin
          if (sample_q < lo_th) begin
            state_d = RAISE;
          end else if (sample_q > hi_th) begin
            state_d = LOWER;
          end
        end
      end
      RAISE: begin
        // Losing enable or config validity overrides the minimum-on time.
        if (!run_ok || (min_done && (sample_q >= raise_exit_th))) begin
          state_d = DEAD;
        end
      end
      LOWER: begin
        if (!run_ok || (min_done && (sample_q <= lower_exit_th))) begin
          state_d = DEAD;
        end
      end
      DEAD: begin
        if (cnt_q == DeadLast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single counter shared by min-on and dead-time: the states using it are exclusive.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == DEAD) ||
                 (((state_q == RAISE) || (state_q == LOWER)) && !min_done)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sample_q      <= '0;
      sample_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (sample_valid) begin
        sample_q      <= sample_data;
        sample_seen_q <= 1'b1;
      end
    end
  end

  assign raise_en = (state_q == RAISE);
  assign lower_en = (state_q == LOWER);

endmodule

// File: rtl/climate_actuator_ctrl.sv
// Closed-loop actuator controller: temperature channel (heater/fan) and humidity
// channel (humidifier/dehumidifier), each an independent hysteresis FSM.
// Ports:
//   pclk, presetn                        clock, async active-low reset
//   ctrl_en                              global enable
//   temp_valid/temp_data, hum_valid/hum_data   sample strobes and data
//   temp_lo_th/temp_hi_th/temp_hyst      temperature thresholds
//   hum_lo_th/hum_hi_th/hum_hyst         humidity thresholds
//   heater_en, fan_en, humidifier_en, dehumidifier_en   actuator enables
//   temp_cfg_err, hum_cfg_err            lo_th >= hi_th per channel
module climate_actuator_ctrl
  import climate_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned MIN_ON_CYC   = 1000,
  parameter int unsigned DEADTIME_CYC = 100
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              ctrl_en,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  input  logic              hum_valid,
  input  logic [DATA_W-1:0] hum_data,
  input  logic [DATA_W-1:0] temp_lo_th,
  input  logic [DATA_W-1:0] temp_hi_th,
  input  logic [DATA_W-1:0] temp_hyst,
  input  logic [DATA_W-1:0] hum_lo_th,
  input  logic [DATA_W-1:0] hum_hi_th,
  input  logic [DATA_W-1:0] hum_hyst,
  output logic              heater_en,
  output logic              fan_en,
  output logic              humidifier_en,
  output logic              dehumidifier_en,
  output logic              temp_cfg_err,
  output logic              hum_cfg_err
);

  actuator_hyst_fsm #(
    .DATA_W      (DATA_W),
    .MIN_ON_CYC  (MIN_ON_CYC),
    .DEADTIME_CYC(DEADTIME_CYC)
  ) u_temp (
    .pclk        (pclk),
    .presetn     (presetn),
    .ctrl_en     (ctrl_en),
    .sample_valid(temp_valid),
    .sample_data (temp_data),
    .lo_th       (temp_lo_th),
    .hi_th       (temp_hi_th),
    .hyst        (temp_hyst),
    .raise_en    (heater_en),
    .lower_en    (fan_en),
    .cfg_err     (temp_cfg_err)
  );

  actuator_hyst_fsm #(
    .DATA_W      (DATA_W),
    .MIN_ON_CYC  (MIN_ON_CYC),
    .DEADTIME_CYC(DEADTIME_CYC)
  ) u_hum (
    .pclk        (pclk),
    .presetn     (presetn),
    .ctrl_en     (ctrl_en),
    .sample_valid(hum_valid),
    .sample_data (hum_data),
    .lo_th       (hum_lo_th),
    .hi_th       (hum_hi_th),
    .hyst        (hum_hyst),
    .raise_en    (humidifier_en),
    .lower_en    (dehumidifier_en),
    .cfg_err     (hum_cfg_err)
  );

endmodule

// File: tb/tb_climate_actuator_ctrl.sv
// Bench for climate_actuator_ctrl: a behavioural channel model pushes the expected
// enables into a queue at every clock edge; scenario tasks pop and compare on the
// falling edge, alongside directed checks of latency, durations and invariants.
module tb_climate_actuator_ctrl;

  localparam int MIN_ON = 8;
  localparam int DEAD_T = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        ctrl_en = 1'b1;
  logic        temp_valid = 1'b0;
  logic [15:0] temp_data = '0;
  logic        hum_valid = 1'b0;
  logic [15:0] hum_data = '0;
  logic [15:0] temp_lo_th = 16'd100;
  logic [15:0] temp_hi_th = 16'd200;
  logic [15:0] temp_hyst = 16'd10;
  logic [15:0] hum_lo_th = 16'd100;
  logic [15:0] hum_hi_th = 16'd200;
  logic [15:0] hum_hyst = 16'd10;
  logic        heater_en, fan_en, humidifier_en, dehumidifier_en;
  logic        temp_cfg_err, hum_cfg_err;

  logic [3:0] en_vec;
  logic [1:0] err_vec;
  logic [1:0] exp_err;
  assign en_vec  = {heater_en, fan_en, humidifier_en, dehumidifier_en};
  assign err_vec = {temp_cfg_err, hum_cfg_err};
  assign exp_err = {temp_lo_th >= temp_hi_th, hum_lo_th >= hum_hi_th};

  int n_vec  = 0;
  int n_fail = 0;

  climate_actuator_ctrl #(
    .DATA_W      (16),
    .MIN_ON_CYC  (MIN_ON),
    .DEADTIME_CYC(DEAD_T)
  ) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .ctrl_en        (ctrl_en),
    .temp_valid     (temp_valid),
    .temp_data      (temp_data),
    .hum_valid      (hum_valid),
    .hum_data       (hum_data),
    .temp_lo_th     (temp_lo_th),
    .temp_hi_th     (temp_hi_th),
    .temp_hyst      (temp_hyst),
    .hum_lo_th      (hum_lo_th),
    .hum_hi_th      (hum_hi_th),
    .hum_hyst       (hum_hyst),
    .heater_en      (heater_en),
    .fan_en         (fan_en),
    .humidifier_en  (humidifier_en),
    .dehumidifier_en(dehumidifier_en),
    .temp_cfg_err   (temp_cfg_err),
    .hum_cfg_err    (hum_cfg_err)
  );

  always #5 pclk = ~pclk;

  // ---------------- reference model + scoreboard ----------------
  // mode: 0 idle, 1 raise, 2 lower, 3 dead; tmr counts cycles spent in the mode.
  typedef struct {
    logic [15:0] smp;
    bit          seen;
    int          mode;
    int          tmr;
  } ch_t;

  ch_t        m_t, m_h;
  logic [3:0] sb_q[$];

  function automatic ch_t next_ch(ch_t s, logic v, logic [15:0] d, logic [15:0] lo,
                                  logic [15:0] hi, logic [15:0] hy, logic en);
    ch_t n;
    int  lo_x, hi_x;
    bit  err;
    n    = s;
    lo_x = int'(lo) + int'(hy);
    if (lo_x > 65535) lo_x = 65535;
    hi_x = int'(hi) - int'(hy);
    if (hi_x < 0) hi_x = 0;
    err = (lo >= hi);
    case (s.mode)
      0: if (s.seen && en && !err) begin
        if (s.smp < lo) begin n.mode = 1; n.tmr = 0; end
        else if (s.smp > hi) begin n.mode = 2; n.tmr = 0; end
      end
      1: if (!en || err || (s.tmr >= MIN_ON - 1 && int'(s.smp) >= lo_x)) begin
        n.mode = 3; n.tmr = 0;
      end else n.tmr = s.tmr + 1;
      2: if (!en || err || (s.tmr >= MIN_ON - 1 && int'(s.smp) <= hi_x)) begin
        n.mode = 3; n.tmr = 0;
      end else n.tmr = s.tmr + 1;
      3: if (s.tmr >= DEAD_T - 1) begin n.mode = 0; n.tmr = 0; end
         else n.tmr = s.tmr + 1;
      default: n.mode = 0;
    endcase
    if (v) begin
      n.smp  = d;
      n.seen = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_of(ch_t t, ch_t h);
    return {t.mode == 1, t.mode == 2, h.mode == 1, h.mode == 2};
  endfunction

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_t <= '{smp: 16'd0, seen: 1'b0, mode: 0, tmr: 0};
      m_h <= '{smp: 16'd0, seen: 1'b0, mode: 0, tmr: 0};
      sb_q.delete();
    end else begin
      m_t <= next_ch(m_t, temp_valid, temp_data, temp_lo_th, temp_hi_th, temp_hyst, ctrl_en);
      m_h <= next_ch(m_h, hum_valid, hum_data, hum_lo_th, hum_hi_th, hum_hyst, ctrl_en);
      sb_q.push_back(exp_of(
        next_ch(m_t, temp_valid, temp_data, temp_lo_th, temp_hi_th, temp_hyst, ctrl_en),
        next_ch(m_h, hum_valid, hum_data, hum_lo_th, hum_hi_th, hum_hyst, ctrl_en)));
    end
  end

  task automatic pop_exp(output logic [3:0] e, output bit got);
    if (sb_q.size() == 0) begin
      e   = 4'bxxxx;
      got = 1'b0;
    end else begin
      e   = sb_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic set_temp(input logic [15:0] d);
    temp_valid = 1'b1;
    temp_data  = d;
  endtask

  task automatic set_hum(input logic [15:0] d);
    hum_valid = 1'b1;
    hum_data  = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [3:0] e;
    bit         got;
    #12;
    n_vec++;
    if (en_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_hold: enables %b, want 0000", en_vec);
    end
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b_%b want %b_%b", i, en_vec, err_vec, e, exp_err);
      end
      temp_valid = 1'b0;
      if (i == 3) set_temp(16'd150);
    end
    n_vec++;
    if (en_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL in_band_150: enables %b, want 0000", en_vec);
    end
  endtask

  task automatic test_heat(input logic [15:0] second, input bit stays_on);
    logic [3:0] e;
    bit         got;
    int         hcnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL heat_%0d cyc %0d: got %b_%b want %b_%b", second, i, en_vec, err_vec,
                 e, exp_err);
      end
      if (heater_en) hcnt++;
      if (i == 1) begin
        n_vec++;
        if (heater_en !== 1'b0) begin
          n_fail++;
          $display("FAIL heat_latency_early: heater_en %b, want 0", heater_en);
        end
      end
      if (i == 2) begin
        n_vec++;
        if (heater_en !== 1'b1) begin
          n_fail++;
          $display("FAIL heat_latency: heater_en %b, want 1", heater_en);
        end
      end
      if (i == 24 && stays_on) begin
        n_vec++;
        if (heater_en !== 1'b1) begin
          n_fail++;
          $display("FAIL heat_hyst_hold: heater_en %b, want 1", heater_en);
        end
      end
      temp_valid = 1'b0;
      if (i == 0) set_temp(16'd90);
      if (i == 1) set_temp(second);
      if (i == 25) set_temp(16'd150);
    end
    if (!stays_on) begin
      n_vec++;
      if (hcnt != MIN_ON) begin
        n_fail++;
        $display("FAIL heat_min_on: heater high %0d cycles, want %0d", hcnt, MIN_ON);
      end
    end
  endtask

  task automatic test_hum_swap();
    logic [3:0] e;
    bit         got;
    bit         both = 1'b0;
    int         last_dh = -1;
    int         first_hu = -1;
    for (int i = 0; i < 70; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL hum_swap cyc %0d: got %b_%b want %b_%b", i, en_vec, err_vec, e, exp_err);
      end
      if (humidifier_en && dehumidifier_en) both = 1'b1;
      if (dehumidifier_en) last_dh = i;
      if (humidifier_en && first_hu < 0) first_hu = i;
      hum_valid = 1'b0;
      if (i == 0) set_hum(16'd210);
      if (i == 14) set_hum(16'd50);
      if (i == 40) set_hum(16'd150);
    end
    n_vec++;
    if (both) begin
      n_fail++;
      $display("FAIL hum_exclusive: both humidity enables seen high, want never");
    end
    n_vec++;
    if (last_dh < 0 || first_hu < 0 || (first_hu - last_dh - 1) < DEAD_T) begin
      n_fail++;
      $display("FAIL hum_deadtime: dehum last %0d hum first %0d, want gap >= %0d",
               last_dh, first_hu, DEAD_T);
    end
  endtask

  task automatic test_ctrl_en();
    logic [3:0] e;
    bit         got;
    int         hcnt = 0;
    int         drop_i = -100;
    bit         reheat = 1'b0;
    for (int i = 0; i < 55; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL ctrl_en cyc %0d: got %b_%b want %b_%b", i, en_vec, err_vec, e, exp_err);
      end
      if (heater_en) hcnt++;
      if (i == drop_i + 1) begin
        n_vec++;
        if (heater_en !== 1'b0) begin
          n_fail++;
          $display("FAIL ctrl_en_drop: heater_en %b, want 0", heater_en);
        end
      end
      if (i > drop_i + 6 && drop_i >= 0 && heater_en) reheat = 1'b1;
      temp_valid = 1'b0;
      if (i == 0) set_temp(16'd90);
      if (hcnt == 2 && drop_i < 0) begin
        ctrl_en = 1'b0;
        drop_i  = i;
      end
      if (i == drop_i + 6) ctrl_en = 1'b1;
      if (i == 25) set_temp(16'd150);
    end
    n_vec++;
    if (!reheat) begin
      n_fail++;
      $display("FAIL ctrl_en_reheat: heater_en never 1 after re-enable, want 1");
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] e;
    bit         got;
    bit         temp_on = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL cfg_err cyc %0d: got %b_%b want %b_%b", i, en_vec, err_vec, e, exp_err);
      end
      if (i >= 1 && i < 16 && (heater_en || fan_en)) temp_on = 1'b1;
      if (i == 1) begin
        n_vec++;
        if (err_vec !== 2'b10) begin
          n_fail++;
          $display("FAIL cfg_err_flag: errs %b, want 10", err_vec);
        end
      end
      if (i == 15) begin
        n_vec++;
        if (dehumidifier_en !== 1'b1) begin
          n_fail++;
          $display("FAIL cfg_err_hum_indep: dehumidifier_en %b, want 1", dehumidifier_en);
        end
      end
      temp_valid = 1'b0;
      hum_valid  = 1'b0;
      if (i == 0) begin
        temp_lo_th = 16'd200;
        temp_hi_th = 16'd100;
        set_temp(16'd50);
        set_hum(16'd210);
      end
      if (i == 15) set_temp(16'd150);
      if (i == 16) begin
        temp_lo_th = 16'd100;
        temp_hi_th = 16'd200;
        set_hum(16'd150);
      end
    end
    n_vec++;
    if (temp_on) begin
      n_fail++;
      $display("FAIL cfg_err_temp_off: temp enable seen high under cfg_err, want never");
    end
  endtask

  task automatic test_sat_reset();
    logic [3:0] e;
    bit         got;
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      pop_exp(e, got);
      n_vec++;
      if (!got || {en_vec, err_vec} !== {e, exp_err}) begin
        n_fail++;
        $display("FAIL sat_reset cyc %0d: got %b_%b want %b_%b", i, en_vec, err_vec,
                 e, exp_err);
      end
      if (i == 24) begin
        n_vec++;
        if (fan_en !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_sub_exit: fan_en %b, want 0", fan_en);
        end
      end
      temp_valid = 1'b0;
      if (i == 0) begin
        temp_lo_th = 16'd0;
        temp_hi_th = 16'd5;
        set_temp(16'd50);
      end
      if (i == 12) set_temp(16'd0);
      if (i == 25) set_temp(16'd50);
      if (i == 30) begin
        n_vec++;
        if (fan_en !== 1'b1) begin
          n_fail++;
          $display("FAIL pre_reset_fan: fan_en %b, want 1", fan_en);
        end
        #2 presetn = 1'b0;
        #1;
        n_vec++;
        if (en_vec !== 4'b0000) begin
          n_fail++;
          $display("FAIL async_reset: enables %b, want 0000", en_vec);
        end
        @(negedge pclk);
        presetn = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_heat(16'd115, 1'b0);
    test_heat(16'd105, 1'b1);
    test_hum_swap();
    test_ctrl_en();
    test_cfg_err();
    test_sat_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
